// File: rtl/mult_rr_arbiter_if.sv
// rtl/mult_rr_arbiter_if.sv - handshake bundle between two requesters, the shared multiplier and the arbiter
//
// Purpose: groups every stream and status signal of mult_rr_arbiter.
//   slave  modport : the arbiter's view (requester operands/result ready in, grants/results out)
//   master modport : the environment's view (requesters, result sinks and the multiplier)
// Signals:
//   s0_/s1_a_tdata, s0_/s1_b_tdata, s0_/s1_tvalid, s0_/s1_tready : requester operand streams
//   r0_/r1_tdata, r0_/r1_tvalid, r0_/r1_tready                   : requester result streams
//   mul_a_tdata, mul_b_tdata, mul_in_tvalid, mul_in_tready       : multiplier operand port
//   mul_out_tdata, mul_out_tvalid, mul_out_tready                : multiplier result port
//   busy, err                                                    : status
interface mult_rr_arbiter_if;
  logic [31:0] s0_a_tdata;
  logic [31:0] s0_b_tdata;
  logic        s0_tvalid;
  logic        s0_tready;
  logic [31:0] s1_a_tdata;
  logic [31:0] s1_b_tdata;
  logic        s1_tvalid;
  logic        s1_tready;
  logic [63:0] r0_tdata;
  logic        r0_tvalid;
  logic        r0_tready;
  logic [63:0] r1_tdata;
  logic        r1_tvalid;
  logic        r1_tready;
  logic [31:0] mul_a_tdata;
  logic [31:0] mul_b_tdata;
  logic        mul_in_tvalid;
  logic        mul_in_tready;
  logic [63:0] mul_out_tdata;
  logic        mul_out_tvalid;
  logic        mul_out_tready;
  logic        busy;
  logic        err;

  modport slave (
    input  s0_a_tdata, s0_b_tdata, s0_tvalid,
    input  s1_a_tdata, s1_b_tdata, s1_tvalid,
    input  r0_tready, r1_tready,
    input  mul_in_tready, mul_out_tdata, mul_out_tvalid,
    output s0_tready, s1_tready,
    output r0_tdata, r0_tvalid, r1_tdata, r1_tvalid,
    output mul_a_tdata, mul_b_tdata, mul_in_tvalid, mul_out_tready,
    output busy, err
  );

  modport master (
    output s0_a_tdata, s0_b_tdata, s0_tvalid,
    output s1_a_tdata, s1_b_tdata, s1_tvalid,
    output r0_tready, r1_tready,
    output mul_in_tready, mul_out_tdata, mul_out_tvalid,
    input  s0_tready, s1_tready,
    input  r0_tdata, r0_tvalid, r1_tdata, r1_tvalid,
    input  mul_a_tdata, mul_b_tdata, mul_in_tvalid, mul_out_tready,
    input  busy, err
  );
endinterface

// File: rtl/mult_rr_arbiter.sv
// rtl/mult_rr_arbiter.sv - round-robin sharing of one pipelined 32x32 multiplier between two requesters
//
// Purpose: grants one of two operand streams per cycle to the multiplier, tags each issue
//   with its requester ID in an in-order tag FIFO, and steers each returning product to
//   the requester whose tag is at the FIFO head. Zero added latency in both directions.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mult_rr_arbiter_if.slave (operand, result, multiplier and status signals)
module mult_rr_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  mult_rr_arbiter_if.slave    bus
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic          r_last_grant;
  logic          r_tags [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic w_full;
  logic w_nonempty;
  logic w_grant_valid;
  logic w_grant_id;
  logic w_head;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);

  // Grant is gated by rst so no requester sees tready while reset is held,
  // even though the counters are already cleared asynchronously.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = 1'b0;
    if (!rst && !w_full) begin
      if (bus.s0_tvalid && !bus.s1_tvalid) begin
        w_grant_valid = 1'b1;
        w_grant_id    = 1'b0;
      end else if (bus.s1_tvalid && !bus.s0_tvalid) begin
        w_grant_valid = 1'b1;
        w_grant_id    = 1'b1;
      end else if (bus.s0_tvalid && bus.s1_tvalid) begin
        w_grant_valid = 1'b1;
        w_grant_id    = ~r_last_grant;
      end
    end
  end

  assign bus.mul_a_tdata   = (w_grant_valid && w_grant_id) ? bus.s1_a_tdata : bus.s0_a_tdata;
  assign bus.mul_b_tdata   = (w_grant_valid && w_grant_id) ? bus.s1_b_tdata : bus.s0_b_tdata;
  assign bus.mul_in_tvalid = w_grant_valid;
  assign bus.s0_tready     = w_grant_valid && !w_grant_id && bus.mul_in_tready;
  assign bus.s1_tready     = w_grant_valid &&  w_grant_id && bus.mul_in_tready;

  assign w_push = w_grant_valid && bus.mul_in_tready;

  // Return steering: the head tag names the owner of the product now on mul_out.
  assign w_head             = r_tags[r_rd_ptr];
  assign bus.r0_tdata       = bus.mul_out_tdata;
  assign bus.r1_tdata       = bus.mul_out_tdata;
  assign bus.r0_tvalid      = bus.mul_out_tvalid && w_nonempty && !w_head;
  assign bus.r1_tvalid      = bus.mul_out_tvalid && w_nonempty &&  w_head;
  assign bus.mul_out_tready = w_nonempty && (w_head ? bus.r1_tready : bus.r0_tready);

  assign w_pop = bus.mul_out_tvalid && bus.mul_out_tready;

  assign bus.busy = w_nonempty;
  assign bus.err  = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tags[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_grant_id;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
        r_last_grant     <= w_grant_id;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      // Push and pop in the same cycle leave the count untouched.
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (bus.mul_out_tvalid && !w_nonempty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb/tb_mult_rr_arbiter.sv - directed self-checking bench for mult_rr_arbiter
module tb_mult_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_rr_arbiter_if ifc();

  mult_rr_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Multiplier model: latency one cycle, results held in order until accepted.
  logic [63:0] prod_q[$];
  logic        m_have = 1'b0;
  logic [63:0] m_head = '0;
  logic        out_en = 1'b1;
  logic        spur   = 1'b0;

  assign ifc.mul_out_tvalid = spur | (m_have & out_en);
  assign ifc.mul_out_tdata  = spur ? 64'hDEAD_BEEF_0000_0001 : m_head;

  always @(posedge clk) begin
    if (rst) begin
      prod_q.delete();
    end else begin
      if (ifc.mul_out_tvalid && ifc.mul_out_tready && !spur) void'(prod_q.pop_front());
      if (ifc.mul_in_tvalid && ifc.mul_in_tready)
        prod_q.push_back(64'(ifc.mul_a_tdata) * 64'(ifc.mul_b_tdata));
    end
    m_have <= (prod_q.size() != 0);
    m_head <= (prod_q.size() != 0) ? prod_q[0] : 64'h0;
  end

  // Monitor of handshakes.
  logic        fired0 = 1'b0;
  logic        fired1 = 1'b0;
  int          issue_cnt = 0;
  int          rv_cnt = 0;
  int          r1_seen = 0;
  logic        glog[$];
  logic [63:0] got0[$];
  logic [63:0] got1[$];

  always @(posedge clk) begin
    fired0 = ifc.s0_tvalid & ifc.s0_tready;
    fired1 = ifc.s1_tvalid & ifc.s1_tready;
    if (fired0 | fired1) begin
      issue_cnt++;
      glog.push_back(fired1);
    end
    if (ifc.r0_tvalid && ifc.r0_tready) got0.push_back(ifc.r0_tdata);
    if (ifc.r1_tvalid && ifc.r1_tready) got1.push_back(ifc.r1_tdata);
    if (ifc.r0_tvalid || ifc.r1_tvalid) rv_cnt++;
    if (ifc.r1_tvalid) r1_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    glog.delete();
    got0.delete();
    got1.delete();
    r1_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b);
    bit done = 1'b0;
    if (id) begin
      ifc.s1_a_tdata = a; ifc.s1_b_tdata = b; ifc.s1_tvalid = 1'b1;
    end else begin
      ifc.s0_a_tdata = a; ifc.s0_b_tdata = b; ifc.s0_tvalid = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      if (id ? fired1 : fired0) begin
        done = 1'b1;
        break;
      end
    end
    ifc.s0_tvalid = 1'b0;
    ifc.s1_tvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: requester %0d not accepted within 50 cycles", id);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (!ifc.busy) break;
      tick();
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b required 0", ifc.busy);
    end
  endtask

  task automatic test_reset();
    ifc.s0_tvalid = 1'b1;
    ifc.s0_a_tdata = 32'd1; ifc.s0_b_tdata = 32'd1;
    #1;
    checks++;
    if ({ifc.s0_tready, ifc.s1_tready, ifc.mul_in_tvalid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: s0_tready/s1_tready/mul_in_tvalid=%b required 000",
               {ifc.s0_tready, ifc.s1_tready, ifc.mul_in_tvalid});
    end
    checks++;
    if ({ifc.r0_tvalid, ifc.r1_tvalid, ifc.mul_out_tready, ifc.busy, ifc.err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: r0v/r1v/mul_out_tready/busy/err=%b required 00000",
               {ifc.r0_tvalid, ifc.r1_tvalid, ifc.mul_out_tready, ifc.busy, ifc.err});
    end
    ifc.s0_tvalid = 1'b0;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_single();
    send(1'b0, 32'd3, 32'd5);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_rise: busy=%b required 1", ifc.busy);
    end
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    checks++;
    if (got0.size() != 2) begin
      errors++;
      $display("FAIL single_count: r0 results=%0d required 2", got0.size());
    end else begin
      checks++;
      if (got0[0] !== 64'd15) begin
        errors++;
        $display("FAIL single_3x5: got %h required %h", got0[0], 64'd15);
      end
      checks++;
      if (got0[1] !== 64'hFFFF_FFFE_0000_0001) begin
        errors++;
        $display("FAIL single_max: got %h required %h", got0[1], 64'hFFFF_FFFE_0000_0001);
      end
    end
    checks++;
    if (r1_seen != 0 || ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL single_r1_err: r1_tvalid cycles=%0d err=%b required 0 and 0", r1_seen, ifc.err);
    end
  endtask

  task automatic test_contention();
    int k0 = 0;
    int k1 = 0;
    int start;
    do_reset();
    ifc.s0_a_tdata = 32'd1; ifc.s0_b_tdata = 32'd2;
    ifc.s1_a_tdata = 32'd1; ifc.s1_b_tdata = 32'd3;
    ifc.s0_tvalid = 1'b1; ifc.s1_tvalid = 1'b1;
    start = issue_cnt;
    for (int i = 0; i < 40 && (issue_cnt - start) < 8; i++) begin
      tick();
      if (fired0) begin k0++; ifc.s0_a_tdata = 32'(k0 + 1); end
      if (fired1) begin k1++; ifc.s1_a_tdata = 32'(k1 + 1); end
      if ((issue_cnt - start) >= 8) begin
        ifc.s0_tvalid = 1'b0; ifc.s1_tvalid = 1'b0;
      end
    end
    ifc.s0_tvalid = 1'b0; ifc.s1_tvalid = 1'b0;
    drain();
    checks++;
    if (glog.size() != 8) begin
      errors++;
      $display("FAIL contention_issues: issued %0d required 8", glog.size());
    end
    for (int i = 0; i < glog.size() && i < 8; i++) begin
      checks++;
      if (glog[i] !== 1'(i % 2)) begin
        errors++;
        $display("FAIL contention_order[%0d]: grant %0d required %0d", i, glog[i], i % 2);
      end
    end
    checks++;
    if (got0.size() != 4 || got1.size() != 4) begin
      errors++;
      $display("FAIL contention_split: r0=%0d r1=%0d required 4 and 4", got0.size(), got1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got0[i] !== 64'((i + 1) * 2) || got1[i] !== 64'((i + 1) * 3)) begin
          errors++;
          $display("FAIL contention_data[%0d]: r0=%0d r1=%0d required %0d %0d",
                   i, got0[i], got1[i], (i + 1) * 2, (i + 1) * 3);
        end
      end
    end
  endtask

  task automatic test_full();
    int start;
    do_reset();
    ifc.r0_tready = 1'b0;
    ifc.s0_a_tdata = 32'd7; ifc.s0_b_tdata = 32'd7;
    ifc.s0_tvalid = 1'b1;
    start = issue_cnt;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (issue_cnt - start != 4) begin
      errors++;
      $display("FAIL full_issues: issued %0d required 4", issue_cnt - start);
    end
    checks++;
    if ({ifc.s0_tready, ifc.busy, ifc.r0_tvalid} !== 3'b011) begin
      errors++;
      $display("FAIL full_state: s0_tready/busy/r0_tvalid=%b required 011",
               {ifc.s0_tready, ifc.busy, ifc.r0_tvalid});
    end
    ifc.r0_tready = 1'b1;
    #1;
    checks++;
    if (ifc.s0_tready !== 1'b0) begin
      errors++;
      $display("FAIL full_no_comb_free: s0_tready=%b required 0", ifc.s0_tready);
    end
    tick();
    checks++;
    if (ifc.s0_tready !== 1'b1) begin
      errors++;
      $display("FAIL full_resume: s0_tready=%b required 1", ifc.s0_tready);
    end
    ifc.s0_tvalid = 1'b0;
    drain();
    checks++;
    if (got0.size() != 4 || (got0.size() == 4 && got0[3] !== 64'd49)) begin
      errors++;
      $display("FAIL full_results: r0 results=%0d required 4 of 49", got0.size());
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    ifc.r0_tready = 1'b1;
    ifc.r1_tready = 1'b0;
    send(1'b1, 32'd2, 32'd3);
    send(1'b0, 32'd4, 32'd5);
    tick();
    tick();
    checks++;
    if ({ifc.mul_out_tready, ifc.r1_tvalid, ifc.r0_tvalid} !== 3'b010) begin
      errors++;
      $display("FAIL bp_hold: mul_out_tready/r1_tvalid/r0_tvalid=%b required 010",
               {ifc.mul_out_tready, ifc.r1_tvalid, ifc.r0_tvalid});
    end
    checks++;
    if (got0.size() != 0) begin
      errors++;
      $display("FAIL bp_r0_early: r0 results=%0d required 0", got0.size());
    end
    ifc.r1_tready = 1'b1;
    tick();
    checks++;
    if (got1.size() != 1 || got0.size() != 0) begin
      errors++;
      $display("FAIL bp_release_order: r1=%0d r0=%0d required 1 and 0", got1.size(), got0.size());
    end
    drain();
    checks++;
    if (got1.size() != 1 || got0.size() != 1 ||
        (got1.size() == 1 && got1[0] !== 64'd6) || (got0.size() == 1 && got0[0] !== 64'd20)) begin
      errors++;
      $display("FAIL bp_data: r1 count %0d r0 count %0d required one 6 and one 20",
               got1.size(), got0.size());
    end
  endtask

  task automatic test_simultaneous();
    int k0 = 0;
    int k1 = 0;
    int start;
    int rets;
    do_reset();
    out_en = 1'b0;
    ifc.s0_a_tdata = 32'd1; ifc.s0_b_tdata = 32'd3;
    ifc.s1_a_tdata = 32'd1; ifc.s1_b_tdata = 32'd7;
    ifc.s0_tvalid = 1'b1; ifc.s1_tvalid = 1'b1;
    start = issue_cnt;
    for (int i = 0; i < 10 && (issue_cnt - start) < 2; i++) begin
      tick();
      if (fired0) begin k0++; ifc.s0_a_tdata = 32'(k0 + 1); end
      if (fired1) begin k1++; ifc.s1_a_tdata = 32'(k1 + 1); end
    end
    out_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (!(ifc.s0_tready || ifc.s1_tready) || ifc.mul_out_tready !== 1'b1) begin
        errors++;
        $display("FAIL simul_cycle[%0d]: issue ready=%b mul_out_tready=%b required 1 and 1",
                 i, ifc.s0_tready | ifc.s1_tready, ifc.mul_out_tready);
      end
      tick();
      if (fired0) begin k0++; ifc.s0_a_tdata = 32'(k0 + 1); end
      if (fired1) begin k1++; ifc.s1_a_tdata = 32'(k1 + 1); end
    end
    ifc.s0_tvalid = 1'b0; ifc.s1_tvalid = 1'b0;
    rets = got0.size() + got1.size();
    drain();
    checks++;
    if (got0.size() + got1.size() - rets != 2) begin
      errors++;
      $display("FAIL simul_remaining: drained %0d required 2", got0.size() + got1.size() - rets);
    end
    checks++;
    if (got0.size() != 6 || got1.size() != 6) begin
      errors++;
      $display("FAIL simul_split: r0=%0d r1=%0d required 6 and 6", got0.size(), got1.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got0[i] !== 64'((i + 1) * 3) || got1[i] !== 64'((i + 1) * 7)) begin
          errors++;
          $display("FAIL simul_data[%0d]: r0=%0d r1=%0d required %0d %0d",
                   i, got0[i], got1[i], (i + 1) * 3, (i + 1) * 7);
        end
      end
    end
  endtask

  task automatic test_err_reset();
    int start;
    do_reset();
    spur = 1'b1;
    #1;
    checks++;
    if ({ifc.mul_out_tready, ifc.r0_tvalid, ifc.r1_tvalid} !== 3'b000) begin
      errors++;
      $display("FAIL spur_ack: mul_out_tready/r0v/r1v=%b required 000",
               {ifc.mul_out_tready, ifc.r0_tvalid, ifc.r1_tvalid});
    end
    tick();
    spur = 1'b0;
    checks++;
    if (ifc.err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b required 1", ifc.err);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ifc.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", ifc.err);
    end
    out_en = 1'b0;
    ifc.s0_a_tdata = 32'd9; ifc.s0_b_tdata = 32'd9;
    ifc.s0_tvalid = 1'b1;
    start = issue_cnt;
    for (int i = 0; i < 20 && (issue_cnt - start) < 3; i++) begin
      tick();
      if ((issue_cnt - start) >= 3) ifc.s0_tvalid = 1'b0;
    end
    ifc.s0_tvalid = 1'b0;
    checks++;
    if (issue_cnt - start != 3 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup: issued %0d busy=%b required 3 and 1", issue_cnt - start, ifc.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ifc.busy, ifc.err, ifc.r0_tvalid, ifc.r1_tvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset: busy/err/r0v/r1v=%b required 0000",
               {ifc.busy, ifc.err, ifc.r0_tvalid, ifc.r1_tvalid});
    end
    tick();
    rst = 1'b0;
    out_en = 1'b1;
    start = rv_cnt;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (rv_cnt != start || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: result valid cycles=%0d busy=%b required 0 and 0",
               rv_cnt - start, ifc.busy);
    end
  endtask

  initial begin
    ifc.s0_a_tdata = '0; ifc.s0_b_tdata = '0; ifc.s0_tvalid = 1'b0;
    ifc.s1_a_tdata = '0; ifc.s1_b_tdata = '0; ifc.s1_tvalid = 1'b0;
    ifc.r0_tready = 1'b1;
    ifc.r1_tready = 1'b1;
    ifc.mul_in_tready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_back_pressure();
    test_simultaneous();
    test_err_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
